// File: rtl/four_in_and_bist_pkg.sv
// Shared definitions for the four-input gate BIST block.
// Holds the controller state encoding, the number of stimulus patterns and
// the default truth tables for the gate under test.
// The truth tables are indexed by {a,b,c,d}, with a as the MSB:
//   e = a & b & c & d, f = ~(a & b & c & d), g = a & b.
package four_in_and_bist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int PATTERN_COUNT = 16;

  localparam logic [15:0] DEF_EXP_E = 16'h8000;
  localparam logic [15:0] DEF_EXP_F = 16'h7FFF;
  localparam logic [15:0] DEF_EXP_G = 16'hF000;

endpackage

// File: rtl/four_in_and_bist_pattern_gen.sv
// Stimulus pattern generator for the four-input gate BIST.
// Keeps a 4-bit pattern index and a hold counter. Each pattern is held for
// HOLD cycles. The index stops at the last pattern; only 'clear' returns it
// to zero.
// Ports:
//   clk, rst       clock and synchronous active-high reset
//   clear          restart at pattern 0, hold count 0 (start of a run)
//   advance        step the hold counter this cycle (controller is running)
//   pattern_idx    current {a,b,c,d} pattern
//   last_hold      hold counter is in the final cycle of the current pattern
//   last_pattern   current pattern is the final one (index 15)
module four_in_and_bist_pattern_gen
  import four_in_and_bist_pkg::*;
#(
  parameter int HOLD = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       advance,
  output logic [3:0] pattern_idx,
  output logic       last_hold,
  output logic       last_pattern
);

  logic [7:0] hold_q, hold_d;
  logic [3:0] idx_q, idx_d;

  assign pattern_idx  = idx_q;
  assign last_hold    = (hold_q == 8'(HOLD - 1));
  assign last_pattern = (idx_q == 4'(PATTERN_COUNT - 1));

  // The index advances only when a pattern's hold window finishes. After the
  // last pattern it stays put, so a,b,c,d cannot wrap back to 0000 within a run.
  always_comb begin
    hold_d = hold_q;
    idx_d  = idx_q;
    if (clear) begin
      hold_d = 8'd0;
      idx_d  = 4'd0;
    end else if (advance) begin
      if (last_hold) begin
        hold_d = 8'd0;
        if (!last_pattern) begin
          idx_d = idx_q + 4'd1;
        end
      end else begin
        hold_d = hold_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q <= 8'd0;
      idx_q  <= 4'd0;
    end else begin
      hold_q <= hold_d;
      idx_q  <= idx_d;
    end
  end

endmodule

// File: rtl/four_in_and_bist.sv
// Built-in self test for a four-input gate block.
// Applies all 16 {a,b,c,d} patterns, holding each one for HOLD cycles. In the
// last hold cycle of each pattern it compares the responses e,f,g with the
// expected truth tables. It then reports a pass/fail summary.
// Ports:
//   clk, rst           clock and synchronous active-high reset
//   start              level; launches a run when the controller is idle
//   a, b, c, d         stimulus to the gate under test (d changes fastest)
//   e, f, g            responses from the gate under test
//   busy               run in progress
//   done               one-cycle pulse at the end of a run
//   pass               no pattern failed; held until the next run starts
//   err_count          number of failing patterns, saturating at 16
//   fail_idx           index of the first failing pattern (when fail_valid)
//   fail_valid         at least one pattern has failed in this run
module four_in_and_bist
  import four_in_and_bist_pkg::*;
#(
  parameter int          HOLD  = 4,
  parameter logic [15:0] EXP_E = DEF_EXP_E,
  parameter logic [15:0] EXP_F = DEF_EXP_F,
  parameter logic [15:0] EXP_G = DEF_EXP_G
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       d,
  input  logic       e,
  input  logic       f,
  input  logic       g,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [4:0] err_count,
  output logic [3:0] fail_idx,
  output logic       fail_valid
);

  state_t     state_q, state_d;
  logic [4:0] err_count_q, err_count_d;
  logic [3:0] fail_idx_q, fail_idx_d;
  logic       fail_valid_q, fail_valid_d;
  logic       pass_q, pass_d;

  logic [3:0] pattern_idx;
  logic       last_hold;
  logic       last_pattern;
  logic       launch;
  logic       in_run;
  logic       compare_now;
  logic       mismatch;

  assign launch      = (state_q == ST_IDLE) && start;
  assign in_run      = (state_q == ST_RUN);
  assign compare_now = in_run && last_hold;
  // A pattern counts as one failure however many of e,f,g are wrong.
  assign mismatch    = (e != EXP_E[pattern_idx]) ||
                       (f != EXP_F[pattern_idx]) ||
                       (g != EXP_G[pattern_idx]);

  assign err_count  = err_count_q;
  assign fail_idx   = fail_idx_q;
  assign fail_valid = fail_valid_q;
  assign pass       = pass_q;

  four_in_and_bist_pattern_gen #(
    .HOLD(HOLD)
  ) u_pattern_gen (
    .clk         (clk),
    .rst         (rst),
    .clear       (launch),
    .advance     (in_run),
    .pattern_idx (pattern_idx),
    .last_hold   (last_hold),
    .last_pattern(last_pattern)
  );

  // Controller: IDLE -> RUN on start, RUN -> DONE after the last compare,
  // then DONE -> IDLE unconditionally. The outputs come only from the
  // registered state and index, so start has no combinational path to a..d.
  always_comb begin
    state_d      = state_q;
    busy         = 1'b0;
    done         = 1'b0;
    {a, b, c, d} = 4'b0000;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        busy         = 1'b1;
        {a, b, c, d} = pattern_idx;
        if (compare_now && last_pattern) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Scoring: clear everything at launch, then update once per pattern. pass is
  // set from the final error count, so it is ready while done is high.
  always_comb begin
    err_count_d  = err_count_q;
    fail_idx_d   = fail_idx_q;
    fail_valid_d = fail_valid_q;
    pass_d       = pass_q;
    if (launch) begin
      err_count_d  = 5'd0;
      fail_idx_d   = 4'd0;
      fail_valid_d = 1'b0;
      pass_d       = 1'b0;
    end else if (compare_now) begin
      if (mismatch) begin
        if (err_count_q != 5'(PATTERN_COUNT)) begin
          err_count_d = err_count_q + 5'd1;
        end
        if (!fail_valid_q) begin
          fail_idx_d   = pattern_idx;
          fail_valid_d = 1'b1;
        end
      end
      if (last_pattern) begin
        pass_d = (err_count_d == 5'd0);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      err_count_q  <= 5'd0;
      fail_idx_q   <= 4'd0;
      fail_valid_q <= 1'b0;
      pass_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      err_count_q  <= err_count_d;
      fail_idx_q   <= fail_idx_d;
      fail_valid_q <= fail_valid_d;
      pass_q       <= pass_d;
    end
  end

endmodule

// File: tb/tb_four_in_and_bist.sv
// Testbench for four_in_and_bist.
// Two instances are used: one with HOLD=4 and one with HOLD=2.
// A behavioural gate model drives e,f,g, and it can inject faults.
// Each launched run pushes its expected summary onto a scoreboard queue.
// The monitor pops and compares that entry when done pulses.
module tb_four_in_and_bist;

  localparam int HOLD_A = 4;
  localparam int HOLD_B = 2;
  localparam logic [15:0] REF_E = 16'h8000;
  localparam logic [15:0] REF_F = 16'h7FFF;
  localparam logic [15:0] REF_G = 16'hF000;

  typedef struct packed {
    logic       pass;
    logic [4:0] err;
    logic [3:0] fidx;
    logic       fvalid;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start_a = 1'b0;
  logic start_b = 1'b0;

  logic a_a, b_a, c_a, d_a, e_a, f_a, g_a, busy_a, done_a, pass_a, fv_a;
  logic [4:0] ec_a;
  logic [3:0] fi_a;
  logic a_b, b_b, c_b, d_b, e_b, f_b, g_b, busy_b, done_b, pass_b, fv_b;
  logic [4:0] ec_b;
  logic [3:0] fi_b;

  int mode_a = 0;
  int run_cyc_a = 0;
  int run_cyc_b = 0;
  int busy_len_a = 0;
  int busy_len_b = 0;
  int done_cnt_a = 0;
  int last_done_cyc_a = 0;
  int cycle = 0;
  int n_checks = 0;
  int n_pass = 0;
  exp_t q_a[$];
  exp_t q_b[$];

  four_in_and_bist #(.HOLD(HOLD_A)) dut_a (
    .clk(clk), .rst(rst), .start(start_a),
    .a(a_a), .b(b_a), .c(c_a), .d(d_a), .e(e_a), .f(f_a), .g(g_a),
    .busy(busy_a), .done(done_a), .pass(pass_a), .err_count(ec_a),
    .fail_idx(fi_a), .fail_valid(fv_a)
  );

  four_in_and_bist #(.HOLD(HOLD_B)) dut_b (
    .clk(clk), .rst(rst), .start(start_b),
    .a(a_b), .b(b_b), .c(c_b), .d(d_b), .e(e_b), .f(f_b), .g(g_b),
    .busy(busy_b), .done(done_b), .pass(pass_b), .err_count(ec_b),
    .fail_idx(fi_b), .fail_valid(fv_b)
  );

  always #5 clk = ~clk;

  // Cycle counters: the global cycle count, and the cycle number within each DUT's current run.
  always @(posedge clk) begin
    cycle     <= cycle + 1;
    run_cyc_a <= busy_a ? run_cyc_a + 1 : 0;
    run_cyc_b <= busy_b ? run_cyc_b + 1 : 0;
  end

  // Gate under test. mode 0 = good AND/NAND/AB, 1 = e stuck-at-0,
  // 2 = f stuck-at-1, 3 = g inverted. A glitch inverts all responses.
  function automatic logic [2:0] gate_model(input logic [3:0] idx, input int mode,
                                            input logic glitch);
    logic re, rf, rg;
    re = &idx;
    rf = ~(&idx);
    rg = idx[3] & idx[2];
    case (mode)
      1: re = 1'b0;
      2: rf = 1'b1;
      3: rg = ~rg;
      default: ;
    endcase
    if (glitch) {re, rf, rg} = ~{re, rf, rg};
    return {re, rf, rg};
  endfunction

  // Expected run summary, derived from the reference truth tables.
  function automatic exp_t expect_run(input int mode);
    exp_t x;
    logic [2:0] r;
    x = '0;
    for (int i = 0; i < 16; i++) begin
      r = gate_model(4'(i), mode, 1'b0);
      if (r[2] != REF_E[i] || r[1] != REF_F[i] || r[0] != REF_G[i]) begin
        if (!x.fvalid) begin
          x.fidx   = 4'(i);
          x.fvalid = 1'b1;
        end
        x.err = x.err + 5'd1;
      end
    end
    x.pass = (x.err == 5'd0);
    return x;
  endfunction

  // DUT A sees no glitches. DUT B sees a glitch in the first cycle of every pattern.
  always_comb {e_a, f_a, g_a} = gate_model({a_a, b_a, c_a, d_a}, mode_a, 1'b0);
  always_comb {e_b, f_b, g_b} = gate_model({a_b, b_b, c_b, d_b}, 0,
                                           busy_b && (run_cyc_b % HOLD_B == 0));

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
  endtask

  // Monitor A: checks the stimulus in each compare cycle. On done it checks
  // the run length and the scoreboard entry.
  always @(negedge clk) begin
    if (busy_a && (run_cyc_a % HOLD_A == HOLD_A - 1))
      checkOutput("abcd_a", 32'({a_a, b_a, c_a, d_a}), 32'(run_cyc_a / HOLD_A));
    if (busy_a) begin
      busy_len_a <= busy_len_a + 1;
    end else begin
      busy_len_a <= 0;
      if (done_a) begin
        exp_t x;
        done_cnt_a      <= done_cnt_a + 1;
        last_done_cyc_a <= cycle;
        checkOutput("busy_len_a", 32'(busy_len_a), 32'(16 * HOLD_A));
        checkOutput("sb_has_entry_a", 32'(q_a.size() != 0), 32'd1);
        if (q_a.size() != 0) begin
          x = q_a.pop_front();
          checkOutput("pass_a", 32'(pass_a), 32'(x.pass));
          checkOutput("err_count_a", 32'(ec_a), 32'(x.err));
          checkOutput("fail_valid_a", 32'(fv_a), 32'(x.fvalid));
          if (x.fvalid) checkOutput("fail_idx_a", 32'(fi_a), 32'(x.fidx));
        end
      end
    end
  end

  // Monitor B: the same checks for the HOLD=2 instance.
  always @(negedge clk) begin
    if (busy_b && (run_cyc_b % HOLD_B == HOLD_B - 1))
      checkOutput("abcd_b", 32'({a_b, b_b, c_b, d_b}), 32'(run_cyc_b / HOLD_B));
    if (busy_b) begin
      busy_len_b <= busy_len_b + 1;
    end else begin
      busy_len_b <= 0;
      if (done_b) begin
        exp_t x;
        checkOutput("busy_len_b", 32'(busy_len_b), 32'(16 * HOLD_B));
        checkOutput("sb_has_entry_b", 32'(q_b.size() != 0), 32'd1);
        if (q_b.size() != 0) begin
          x = q_b.pop_front();
          checkOutput("pass_b", 32'(pass_b), 32'(x.pass));
          checkOutput("err_count_b", 32'(ec_b), 32'(x.err));
          checkOutput("fail_valid_b", 32'(fv_b), 32'(x.fvalid));
        end
      end
    end
  end

  task automatic applyStimulus(input int mode);
    mode_a = mode;
    q_a.push_back(expect_run(mode));
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
  endtask

  // Waits (bounded) for done on A. Then steps one cycle and checks that done
  // was a single pulse and that pass is held.
  task automatic waitDoneA(input logic exp_pass);
    int n;
    n = 0;
    while (!done_a && n < 16 * HOLD_A + 10) begin
      @(negedge clk);
      n++;
    end
    checkOutput("done_seen_a", 32'(done_a), 32'd1);
    @(negedge clk);
    checkOutput("done_pulse_a", 32'(done_a), 32'd0);
    checkOutput("pass_held_a", 32'(pass_a), 32'(exp_pass));
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_busy"}, 32'(busy_a), 32'd0);
    checkOutput({tag, "_done"}, 32'(done_a), 32'd0);
    checkOutput({tag, "_pass"}, 32'(pass_a), 32'd0);
    checkOutput({tag, "_err"}, 32'(ec_a), 32'd0);
    checkOutput({tag, "_fidx"}, 32'(fi_a), 32'd0);
    checkOutput({tag, "_fvalid"}, 32'(fv_a), 32'd0);
    checkOutput({tag, "_abcd"}, 32'({a_a, b_a, c_a, d_a}), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int c1;
    int n;
    exp_t xb;
    repeat (3) @(negedge clk);
    checkResetState("reset");
    rst = 1'b0;
    @(negedge clk);

    // Good gate, then the three fault models.
    applyStimulus(0);
    waitDoneA(1'b1);
    applyStimulus(1);
    waitDoneA(1'b0);
    applyStimulus(2);
    waitDoneA(1'b0);
    applyStimulus(3);
    waitDoneA(1'b0);

    // start pulses while busy must not restart the run.
    applyStimulus(0);
    repeat (10) @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (20) @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    waitDoneA(1'b1);
    checkOutput("no_restart_a", 32'(busy_a), 32'd0);

    // Reset in run cycle 30 aborts the run: no done pulse.
    applyStimulus(3);
    repeat (29) @(negedge clk);
    checkOutput("errs_before_rst", 32'(ec_a != 5'd0), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkResetState("midrun_rst");
    q_a.delete();
    c1 = done_cnt_a;
    repeat (80) @(negedge clk);
    checkOutput("no_done_after_rst", 32'(done_cnt_a), 32'(c1));
    applyStimulus(0);
    waitDoneA(1'b1);

    // With start held high, runs repeat back to back.
    // Consecutive done pulses are 16*HOLD+2 cycles apart (RUN, DONE, IDLE).
    q_a.push_back(expect_run(0));
    q_a.push_back(expect_run(0));
    mode_a = 0;
    start_a = 1'b1;
    waitDoneA(1'b1);
    c1 = last_done_cyc_a;
    waitDoneA(1'b1);
    start_a = 1'b0;
    checkOutput("b2b_spacing", 32'(last_done_cyc_a - c1), 32'(16 * HOLD_A + 2));
    repeat (4) @(negedge clk);
    checkOutput("b2b_stopped", 32'(busy_a), 32'd0);
    checkOutput("sb_drained_a", 32'(q_a.size()), 32'd0);

    // HOLD=2 instance with a response glitch in the first hold cycle of each pattern.
    xb = expect_run(0);
    q_b.push_back(xb);
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    n = 0;
    while (!done_b && n < 16 * HOLD_B + 10) begin
      @(negedge clk);
      n++;
    end
    checkOutput("done_seen_b", 32'(done_b), 32'd1);
    @(negedge clk);
    checkOutput("sb_drained_b", 32'(q_b.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
